microcode_fetch: RTL and testbench
==================================

// Module: microcode_fetch
// PURPOSE
//  Initiator side of the microcode ROM read interface: the fetch unit of the microcoded controller.
//  Holds the micro-program counter (PC) and issues ROM_readEnable/ROM_address to the ROM.
//  Absorbs the ROM's 1-cycle registered read latency and presents each instruction word
//  to the decode/execute stage through a valid/ready handshake.
//  Applies taken branches on acceptance and stops on a HALT opcode.
// PARAMETERS
//  ROM_addressBits  6  PC / ROM address width; program depth = 2**ROM_addressBits words
//  RF_addressBits   3  register-file address width; instruction width IW = 4+2*RF_addressBits
// PORTS
//  clk             in   1                single clock, all state on posedge
//  rst_n           in   1                asynchronous, active-low reset
//  start           in   1                1-cycle pulse; begins fetching from PC=0 (honoured in IDLE/HALTED only)
//  ROM_readEnable  out  1                read strobe to ROM
//  ROM_address     out  ROM_addressBits  word address to ROM (= PC)
//  ROM_data        in   IW               ROM read data; valid the cycle after ROM_readEnable
//  instr           out  IW               fetched instruction word, held stable while instr_valid=1
//  instr_valid     out  1                instr holds an unconsumed instruction
//  instr_ready     in   1                consumer accepts instr this cycle (handshake = valid & ready)
//  branch_taken    in   1                sampled only on the accept cycle; redirect PC
//  branch_target   in   ROM_addressBits  next PC when branch_taken
//  pc              out  ROM_addressBits  address of the instruction in instr / being fetched
//  halted          out  1                HALT instruction consumed; fetch stopped
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; PC=0; ROM_readEnable=0; ROM_address=0; instr=0;
//    instr_valid=0; halted=0. A reset mid-fetch or mid-handshake abandons it; no partial output.
//  FSM states (enum in package): IDLE, FETCH, WAIT, ISSUE, HALTED.
//   IDLE:   ROM_readEnable=0. start=1 -> PC<=0, go FETCH.
//   FETCH:  ROM_readEnable=1, ROM_address=PC (combinational from PC); go WAIT unconditionally.
//   WAIT:   ROM_readEnable=0. ROM_data is valid; instr<=ROM_data, instr_valid<=1, go ISSUE.
//   ISSUE:  instr_valid=1, instr and pc held constant until instr_valid & instr_ready.
//           On accept: instr_valid<=0.
//             If opcode (instr[IW-1:IW-4]) == OP_HALT -> halted<=1, go HALTED; PC unchanged.
//             Else if branch_taken -> PC<=branch_target, go FETCH.
//             Else PC<=PC+1 modulo 2**ROM_addressBits (last word wraps to 0), go FETCH.
//   HALTED: ROM_readEnable=0, halted=1. start=1 -> halted<=0, PC<=0, go FETCH.
//  ROM_readEnable is asserted only in FETCH, for exactly 1 cycle per instruction.
//  Latency: start in cycle 0 -> ROM_readEnable in cycle 1 -> instr_valid in cycle 3.
//    Sustained throughput with instr_ready tied high: 1 instruction per 3 cycles.
//  start outside IDLE/HALTED is ignored.
//  branch_taken/branch_target outside the accept cycle are ignored.
//  branch_taken together with a HALT opcode: HALT wins.
//  instr_ready while instr_valid=0 has no effect.
//  All outputs registered except ROM_address (=PC register) and ROM_readEnable (state decode).
// STRUCTURE
//  microcode_pkg:
//    fetch_state_t enum
//    OPCODE_BITS=4
//    OP_HALT=4'b1111
//    field-slice helper for opcode / RF address A / RF address B
//  Single module. The PC counter and FSM are too small to justify a sub-module.
//  The ROM itself is instantiated at the controller top level, not inside this block.
// TESTING (bench instantiates the ROM with a known microcode.mem)
//  1. Reset mid-run: rst_n low while state=WAIT
//     -> instr_valid=0, ROM_readEnable=0, pc=0 immediately, without waiting for a clock edge.
//  2. Basic fetch: mem[0]=0x012, mem[1]=0x0A5, start pulse, instr_ready=1
//     -> ROM_readEnable in cycle 1 with addr 0; instr=0x012 valid in cycle 3;
//        addr 1 fetched in cycle 4; instr=0x0A5 valid in cycle 6.
//  3. Backpressure: instr_ready=0 for 5 cycles in ISSUE
//     -> instr, pc and instr_valid stable; no ROM_readEnable pulse until accept.
//  4. Branch: accept instr at pc=3 with branch_taken=1, target=0x2A
//     -> next ROM_address=0x2A; branch_taken=1 on a non-accept cycle changes nothing.
//  5. Wrap: pc=63 with a non-branch instr accepted -> next ROM_address=0.
//  6. Halt: mem[2]=0x3C0 (opcode F), accept it with branch_taken=1
//     -> halted=1, no further ROM_readEnable; a later start pulse -> fetch restarts at addr 0, halted=0.

Source files
------------

// File: rtl/microcode_fetch_pkg.sv
// Shared types and helpers for the microcode fetch unit.
//   fetch_state_t : fetch FSM state encoding
//   OPCODE_BITS   : width of the opcode field at the top of each instruction word
//   OP_HALT       : opcode that stops fetching once consumed
//   field helpers : extract opcode / RF address A / RF address B from an instruction word
package microcode_fetch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StIssue,
        StHalted
    } fetch_state_t;

    localparam int unsigned OPCODE_BITS = 4;
    localparam logic [OPCODE_BITS-1:0] OP_HALT = 4'b1111;

    // Widest instruction word the helpers accept; callers zero-extend into this.
    localparam int unsigned WORD_MAX = 32;

    // Word layout, MSB first: opcode | RF address A | RF address B.
    // msb_off counts bits down from the top of an iw-bit word.
    function automatic logic [7:0] field_slice(input logic [WORD_MAX-1:0] word,
                                               input int unsigned         iw,
                                               input int unsigned         msb_off,
                                               input int unsigned         width);
        logic [WORD_MAX-1:0] mask;
        mask = (WORD_MAX'(1) << width) - WORD_MAX'(1);
        return 8'((word >> (iw - msb_off - width)) & mask);
    endfunction

    function automatic logic [OPCODE_BITS-1:0] opcode_of(input logic [WORD_MAX-1:0] word,
                                                         input int unsigned         iw);
        return OPCODE_BITS'(field_slice(word, iw, 0, OPCODE_BITS));
    endfunction

    function automatic logic [7:0] rf_a_of(input logic [WORD_MAX-1:0] word,
                                           input int unsigned         iw,
                                           input int unsigned         rf_bits);
        return field_slice(word, iw, OPCODE_BITS, rf_bits);
    endfunction

    function automatic logic [7:0] rf_b_of(input logic [WORD_MAX-1:0] word,
                                           input int unsigned         iw,
                                           input int unsigned         rf_bits);
        return field_slice(word, iw, OPCODE_BITS + rf_bits, rf_bits);
    endfunction

endpackage

// File: rtl/microcode_fetch_if.sv
// Bus between the fetch unit, the microcode ROM and the decode/execute stage.
//   master : fetch unit side (drives ROM strobe/address and the instruction handshake)
//   slave  : environment side (ROM data, consumer ready, branch redirect, start)
interface microcode_fetch_if #(
    parameter int unsigned ROM_addressBits = 6,
    parameter int unsigned RF_addressBits  = 3
);
    localparam int unsigned IW = 4 + 2 * RF_addressBits;

    logic                       start;
    logic                       ROM_readEnable;
    logic [ROM_addressBits-1:0] ROM_address;
    logic [IW-1:0]              ROM_data;
    logic [IW-1:0]              instr;
    logic                       instr_valid;
    logic                       instr_ready;
    logic                       branch_taken;
    logic [ROM_addressBits-1:0] branch_target;
    logic [ROM_addressBits-1:0] pc;
    logic                       halted;

    modport master (
        input  start, ROM_data, instr_ready, branch_taken, branch_target,
        output ROM_readEnable, ROM_address, instr, instr_valid, pc, halted
    );

    modport slave (
        output start, ROM_data, instr_ready, branch_taken, branch_target,
        input  ROM_readEnable, ROM_address, instr, instr_valid, pc, halted
    );

endinterface

// File: rtl/microcode_fetch.sv
// Microcode fetch unit: owns the micro-PC, reads the ROM (1-cycle registered
// latency), and offers each word to decode/execute through valid/ready.
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : microcode_fetch_if.master (start, ROM strobe/address/data,
//           instr/instr_valid/instr_ready, branch redirect, pc, halted)
module microcode_fetch
    import microcode_fetch_pkg::*;
#(
    parameter int unsigned ROM_addressBits = 6,
    parameter int unsigned RF_addressBits  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    microcode_fetch_if.master  bus
);

    localparam int unsigned IW = 4 + 2 * RF_addressBits;
    localparam int unsigned AW = ROM_addressBits;

    fetch_state_t          state_q, state_d;
    logic [AW-1:0]         pc_q, pc_d;
    logic [IW-1:0]         instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic                  halted_q, halted_d;
    logic [OPCODE_BITS-1:0] opcode;

    assign opcode = opcode_of(WORD_MAX'(instr_q), IW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    pc_d    = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StWait;
            end
            StWait: begin
                // ROM output register now holds the word addressed during StFetch.
                instr_d = bus.ROM_data;
                valid_d = 1'b1;
                state_d = StIssue;
            end
            StIssue: begin
                if (bus.instr_ready) begin
                    valid_d = 1'b0;
                    // HALT takes priority over any redirect presented with it.
                    if (opcode == OP_HALT) begin
                        halted_d = 1'b1;
                        state_d  = StHalted;
                    end else if (bus.branch_taken) begin
                        pc_d    = bus.branch_target;
                        state_d = StFetch;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = StFetch;
                    end
                end
            end
            StHalted: begin
                if (bus.start) begin
                    halted_d = 1'b0;
                    pc_d     = '0;
                    state_d  = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.ROM_readEnable = (state_q == StFetch);
    assign bus.ROM_address    = pc_q;
    assign bus.instr          = instr_q;
    assign bus.instr_valid    = valid_q;
    assign bus.pc             = pc_q;
    assign bus.halted         = halted_q;

endmodule

// File: tb/tb_microcode_fetch.sv
// Self-checking bench for microcode_fetch with a behavioural 1-cycle ROM.
module tb_microcode_fetch;
    import microcode_fetch_pkg::*;

    localparam int unsigned AW    = 6;
    localparam int unsigned RFB   = 3;
    localparam int unsigned IW    = 4 + 2 * RFB;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    microcode_fetch_if #(.ROM_addressBits(AW), .RF_addressBits(RFB)) bus ();

    microcode_fetch #(.ROM_addressBits(AW), .RF_addressBits(RFB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    logic [IW-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (bus.ROM_readEnable) bus.ROM_data <= mem[bus.ROM_address];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (bus.instr_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid_timeout"}, 32'(bus.instr_valid), 32'd1);
    endtask

    typedef struct {
        int            delay;
        logic          br;
        logic [AW-1:0] tgt;
        logic [AW-1:0] exp_pc;
        logic [IW-1:0] exp_instr;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] nxt;
        logic [AW-1:0] model_pc;
        logic          model_halted;
        int            halt_wait;
        int            accepts;
        logic          rdy, br;
        logic [AW-1:0] tgt;
        logic [3:0]    op;

        bus.start         = 1'b0;
        bus.instr_ready   = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;

        for (int i = 0; i < int'(DEPTH); i++) mem[i] = IW'(32'h100 | i);
        mem[0]    = 10'h012;
        mem[1]    = 10'h0A5;
        mem[2]    = 10'h3C0;
        mem[3]    = 10'h111;
        mem[6'h2A] = 10'h155;
        mem[63]   = 10'h077;

        vecs[0] = '{0, 1'b0, 6'd0,  6'd0,  10'h012};
        vecs[1] = '{0, 1'b1, 6'd3,  6'd1,  10'h0A5};
        vecs[2] = '{5, 1'b1, 6'h2A, 6'd3,  10'h111};
        vecs[3] = '{0, 1'b0, 6'd0,  6'h2A, 10'h155};
        vecs[4] = '{2, 1'b1, 6'd63, 6'h2B, 10'h12B};
        vecs[5] = '{0, 1'b0, 6'd0,  6'd63, 10'h077};
        vecs[6] = '{0, 1'b0, 6'd0,  6'd0,  10'h012};
        vecs[7] = '{0, 1'b0, 6'd0,  6'd1,  10'h0A5};
        vecs[8] = '{1, 1'b1, 6'd5,  6'd2,  10'h3C0};

        // Reset state
        #12;
        check("rst_valid",  32'(bus.instr_valid),    32'd0);
        check("rst_re",     32'(bus.ROM_readEnable), 32'd0);
        check("rst_pc",     32'(bus.pc),             32'd0);
        check("rst_instr",  32'(bus.instr),          32'd0);
        check("rst_halted", 32'(bus.halted),         32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic fetch timing, instr_ready tied high
        @(negedge clk);
        bus.start       = 1'b1;
        bus.instr_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("c1_re",    32'(bus.ROM_readEnable), 32'd1);
        check("c1_addr",  32'(bus.ROM_address),    32'd0);
        check("c1_valid", 32'(bus.instr_valid),    32'd0);
        @(negedge clk);
        check("c2_re",    32'(bus.ROM_readEnable), 32'd0);
        check("c2_valid", 32'(bus.instr_valid),    32'd0);
        @(negedge clk);
        check("c3_valid", 32'(bus.instr_valid),    32'd1);
        check("c3_instr", 32'(bus.instr),          32'h012);
        @(negedge clk);
        check("c4_re",    32'(bus.ROM_readEnable), 32'd1);
        check("c4_addr",  32'(bus.ROM_address),    32'd1);
        @(negedge clk);
        check("c5_valid", 32'(bus.instr_valid),    32'd0);
        @(negedge clk);
        check("c6_valid", 32'(bus.instr_valid),    32'd1);
        check("c6_instr", 32'(bus.instr),          32'h0A5);
        check("c6_pc",    32'(bus.pc),             32'd1);
        bus.instr_ready = 1'b0;

        // start while issuing is ignored
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("ign_start_valid", 32'(bus.instr_valid),    32'd1);
        check("ign_start_pc",    32'(bus.pc),             32'd1);
        check("ign_start_re",    32'(bus.ROM_readEnable), 32'd0);

        // Asynchronous reset while waiting on ROM data
        bus.instr_ready = 1'b1;
        @(posedge clk); #1;
        bus.instr_ready = 1'b0;
        @(posedge clk); #2;
        check("pre_rst_pc", 32'(bus.pc), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.instr_valid),    32'd0);
        check("mid_rst_re",    32'(bus.ROM_readEnable), 32'd0);
        check("mid_rst_pc",    32'(bus.pc),             32'd0);
        check("mid_rst_instr", 32'(bus.instr),          32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven program walk: backpressure, branch, wrap, halt
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 9; r++) begin
            wait_valid($sformatf("row%0d", r));
            for (int d = 0; d < vecs[r].delay; d++) begin
                bus.instr_ready   = 1'b0;
                bus.branch_taken  = 1'b1;
                bus.branch_target = AW'($urandom_range(0, DEPTH - 1));
                check($sformatf("row%0d_hold_instr", r), 32'(bus.instr), 32'(vecs[r].exp_instr));
                check($sformatf("row%0d_hold_pc", r),    32'(bus.pc),    32'(vecs[r].exp_pc));
                check($sformatf("row%0d_hold_re", r),    32'(bus.ROM_readEnable), 32'd0);
                @(negedge clk);
                check($sformatf("row%0d_hold_valid", r), 32'(bus.instr_valid), 32'd1);
            end
            check($sformatf("row%0d_instr", r), 32'(bus.instr), 32'(vecs[r].exp_instr));
            check($sformatf("row%0d_pc", r),    32'(bus.pc),    32'(vecs[r].exp_pc));
            bus.instr_ready   = 1'b1;
            bus.branch_taken  = vecs[r].br;
            bus.branch_target = vecs[r].tgt;
            @(posedge clk); #1;
            bus.instr_ready  = 1'b0;
            bus.branch_taken = 1'b0;
            @(negedge clk);
            check($sformatf("row%0d_post_valid", r), 32'(bus.instr_valid), 32'd0);
            if (vecs[r].exp_instr[IW-1 -: 4] == OP_HALT) begin
                check($sformatf("row%0d_halted", r), 32'(bus.halted),         32'd1);
                check($sformatf("row%0d_re", r),     32'(bus.ROM_readEnable), 32'd0);
            end else begin
                nxt = vecs[r].br ? vecs[r].tgt : AW'((int'(vecs[r].exp_pc) + 1) % DEPTH);
                check($sformatf("row%0d_re", r),   32'(bus.ROM_readEnable), 32'd1);
                check($sformatf("row%0d_next", r), 32'(bus.ROM_address),    32'(nxt));
            end
        end

        // Halted: no fetches, pc held
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("halt_hold_halted", 32'(bus.halted),         32'd1);
            check("halt_hold_re",     32'(bus.ROM_readEnable), 32'd0);
            check("halt_hold_pc",     32'(bus.pc),             32'd2);
        end
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("restart_re",     32'(bus.ROM_readEnable), 32'd1);
        check("restart_addr",   32'(bus.ROM_address),    32'd0);
        check("restart_halted", 32'(bus.halted),         32'd0);
        wait_valid("restart");
        check("restart_instr",  32'(bus.instr),          32'h012);

        // Randomized run against a transaction-level model
        rst_n = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            op = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 9) == 0) op = OP_HALT;
            mem[i] = {op, 6'($urandom_range(0, 63))};
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.start    = 1'b1;
        model_pc     = '0;
        model_halted = 1'b0;
        halt_wait    = 0;
        accepts      = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            rdy = 1'($urandom_range(0, 1));
            br  = 1'($urandom_range(0, 1));
            tgt = AW'($urandom_range(0, DEPTH - 1));
            bus.instr_ready   = rdy;
            bus.branch_taken  = br;
            bus.branch_target = tgt;
            if (bus.ROM_readEnable) check("rnd_addr", 32'(bus.ROM_address), 32'(model_pc));
            if (model_halted) begin
                check("rnd_halted", 32'(bus.halted),         32'd1);
                check("rnd_halt_re", 32'(bus.ROM_readEnable), 32'd0);
                halt_wait++;
                if (halt_wait == 3) begin
                    bus.start    = 1'b1;
                    model_halted = 1'b0;
                    model_pc     = '0;
                    halt_wait    = 0;
                end
            end else if (bus.instr_valid) begin
                check("rnd_instr", 32'(bus.instr), 32'(mem[model_pc]));
                check("rnd_pc",    32'(bus.pc),    32'(model_pc));
                if (rdy) begin
                    accepts++;
                    if (mem[model_pc][IW-1 -: 4] == OP_HALT) model_halted = 1'b1;
                    else if (br) model_pc = tgt;
                    else model_pc = AW'((int'(model_pc) + 1) % DEPTH);
                end
            end
        end
        check("rnd_progress", 32'(accepts > 50), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
